if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter PC_W, default 8, program-counter and ROM address width.
REQ-002 Parameter RESET_PC, default 8'h00, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 stall  input  1  hazard stall from downstream; 1 = hold IF_ID outputs and stop fetching.
REQ-006 rom_rd_en  output  1  ROM read strobe; data returns on rom_data exactly one cycle later.
REQ-007 rom_addr  output  PC_W  ROM read address (current PC).
REQ-008 rom_data  input  16  instruction word: [15:13] opcode, [12:8] ad1, [7:0] imm.
REQ-009 out_opcode  output  3  IF_ID opcode to decode stage.
REQ-010 out_ad1  output  5  IF_ID register-address field.
REQ-011 out_imm  output  8  IF_ID immediate field.
REQ-012 out_pc  output  PC_W  address of the instruction held in IF_ID.
REQ-013 out_valid  output  1  1 = IF_ID holds a fetched instruction; 0 = bubble (opcode 000).
REQ-014 halted  output  1  1 = HLT fetched; fetch permanently stopped until reset.

Function
REQ-015 Two states SHALL exist: RUN and HALTED; RUN -> HALTED when an opcode 3'b111 word is loaded into IF_ID; HALTED exits only by reset.
REQ-016 rom_rd_en SHALL be 1 exactly when state is RUN and stall is 0; rom_addr SHALL equal PC.
REQ-017 PC SHALL increment by 1 on every edge where rom_rd_en is 1, wrapping from 2^PC_W-1 to 0; otherwise hold.
REQ-018 A pending flag plus pending-address register SHALL track the single in-flight request; the returned word SHALL be tagged with that address for out_pc.
REQ-019 Returned word with stall 0 SHALL load into IF_ID at the same edge; out_valid 1 next cycle.
REQ-020 Returned word with stall 1 SHALL be captured in a one-entry hold buffer (word + address); IF_ID unchanged.
REQ-021 When stall is 0 and the hold buffer is full, IF_ID SHALL load from the hold buffer and empty it; a request issued that cycle is legal (returns into an empty buffer).
REQ-022 Pending response and full hold buffer SHALL never coexist; no more than one request is ever in flight.
REQ-023 With stall 0 and neither a pending response nor a full hold buffer, IF_ID SHALL load a bubble: opcode 000, ad1 0, imm 0, out_valid 0, out_pc unchanged.
REQ-024 With stall 1, all IF_ID outputs SHALL hold, including a bubble or an HLT.
REQ-025 Latency: first request in the first cycle after reset release; that instruction appears on IF_ID outputs two rising edges after release; steady state one instruction per cycle.
REQ-026 HLT SHALL be presented on IF_ID with out_valid 1 for one unstalled cycle, then bubbles; halted SHALL be 1 from the cycle HLT appears on IF_ID.
REQ-027 Any ROM response returning while state is HALTED (request issued alongside the HLT load) SHALL be discarded; the hold buffer SHALL be cleared on entering HALTED.
REQ-028 Stall and HLT arriving simultaneously: HLT goes to the hold buffer; HALTED is entered only when it reaches IF_ID.

Reset
REQ-029 On rst: PC = RESET_PC, state RUN, pending 0, hold buffer empty, IF_ID = bubble, out_pc 0, out_valid 0, halted 0, rom_rd_en 0.
REQ-030 Reset asserted mid-operation SHALL abandon any in-flight request; the response cycle after release SHALL NOT be captured.

Structure
REQ-031 Shared package cpu_pkg SHALL hold opcode constants (NOP 000 ... HLT 111), instruction field positions, and the instruction width 16.
REQ-032 The hold buffer SHALL be a sub-module if_hold_buf (one entry, load/drain/clear, full flag); everything else stays inline.

Verification
REQ-033 Reset release, ROM[0..3]=2100,4203,A305,E000, no stall -> outputs at cycles 2..5 = LDO/LDA/ADD/HLT, out_pc 0..3, halted 1 from cycle 5, rom_rd_en 0 after.
REQ-034 stall pulsed 1 for 3 cycles the cycle after request for PC 1 -> PC 1 word held in buffer, IF_ID frozen 3 cycles, then PC 1, 2 in order, no loss or duplicate.
REQ-035 HLT at PC 4, ROM[5]=2100 -> request for PC 5 issued and its response discarded; out_valid 0 thereafter; PC stops at 6.
REQ-036 PC_W=8, RESET_PC=FE, NOP-free ROM of LDO words -> out_pc sequence FE, FF, 00, 01.
REQ-037 rst asserted one cycle after a request -> all outputs to reset values immediately; after release first out_pc = RESET_PC.
REQ-038 stall held 1 while HLT is in the hold buffer -> halted stays 0 until stall drops; then HLT on IF_ID and halted 1.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions for the instruction-fetch stage.
//               Includes the instruction width, the bit positions of each
//               field, the opcode constants and the fetch-state type.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int INSTR_W = 16;

    // Instruction word layout: [15:13] opcode, [12:8] ad1, [7:0] imm
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int AD1_MSB = 12;
    localparam int AD1_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam int OPC_W = OPC_MSB - OPC_LSB + 1;
    localparam int AD1_W = AD1_MSB - AD1_LSB + 1;
    localparam int IMM_W = IMM_MSB - IMM_LSB + 1;

    localparam logic [OPC_W-1:0] OP_NOP = 3'b000;
    localparam logic [OPC_W-1:0] OP_LDO = 3'b001;
    localparam logic [OPC_W-1:0] OP_LDA = 3'b010;
    localparam logic [OPC_W-1:0] OP_STO = 3'b011;
    localparam logic [OPC_W-1:0] OP_SUB = 3'b100;
    localparam logic [OPC_W-1:0] OP_ADD = 3'b101;
    localparam logic [OPC_W-1:0] OP_JMP = 3'b110;
    localparam logic [OPC_W-1:0] OP_HLT = 3'b111;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } if_state_t;

    function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_hold_buf
// Description : A one-entry buffer for a ROM response that arrives while the
//               decode stage is stalled. It stores the instruction word
//               together with its fetch address.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               i_load         - capture i_word/i_addr, mark full
//               i_drain        - entry consumed, mark empty
//               i_clear        - discard the entry (takes priority)
//               i_word/i_addr  - word and address to capture
//               o_full         - entry valid
//               o_word/o_addr  - stored word and address
// Revision    : 1.0 - initial release
// ============================================================================
module if_hold_buf
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_drain,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_word,
    input  logic [PC_W-1:0]    i_addr,
    output logic               o_full,
    output logic [INSTR_W-1:0] o_word,
    output logic [PC_W-1:0]    o_addr
);

    logic               r_full;
    logic [INSTR_W-1:0] r_word;
    logic [PC_W-1:0]    r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_word <= '0;
            r_addr <= '0;
        end else begin
            if (i_clear) begin
                r_full <= 1'b0;
            end else if (i_load) begin
                r_full <= 1'b1;
                r_word <= i_word;
                r_addr <= i_addr;
            end else if (i_drain) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_full = r_full;
    assign o_word = r_word;
    assign o_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : The instruction-fetch stage. It drives a ROM that has one
//               cycle of read latency and loads the IF_ID pipeline register.
//               A stall from downstream freezes IF_ID and stops fetching.
//               Fetching stops permanently after an HLT instruction reaches
//               IF_ID.
// Ports       : clk, rst             - clock, asynchronous active-high reset
//               stall                - hold IF_ID, suppress fetch
//               rom_rd_en/rom_addr   - ROM read strobe and address (PC)
//               rom_data             - ROM word, valid one cycle after strobe
//               out_opcode/ad1/imm   - IF_ID instruction fields
//               out_pc               - address of the IF_ID instruction
//               out_valid            - IF_ID holds an instruction (0 = bubble)
//               halted               - HLT has reached IF_ID
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    output logic               rom_rd_en,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [AD1_W-1:0]   out_ad1,
    output logic [IMM_W-1:0]   out_imm,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_valid,
    output logic               halted
);

    localparam logic [PC_W-1:0] C_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    if_state_t          r_state;
    if_state_t          w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic               r_pend;
    logic [PC_W-1:0]    r_pend_addr;

    logic [OPC_W-1:0]   r_opcode;
    logic [AD1_W-1:0]   r_ad1;
    logic [IMM_W-1:0]   r_imm;
    logic [PC_W-1:0]    r_out_pc;
    logic               r_valid;

    logic               w_rd_en;
    logic               w_rsp;
    logic               w_hb_full;
    logic [INSTR_W-1:0] w_hb_word;
    logic [PC_W-1:0]    w_hb_addr;
    logic               w_from_hb;
    logic               w_ld;
    logic [INSTR_W-1:0] w_ld_word;
    logic [PC_W-1:0]    w_ld_addr;
    logic               w_ld_hlt;

    // A response returning after HALTED has been entered belongs to the
    // request that was issued alongside the HLT load. It is dropped here.
    assign w_rsp     = r_pend && (r_state == ST_RUN);

    // A buffered word is always older than a live response. When the
    // buffer drains, no response can be in flight.
    assign w_from_hb = !stall && w_hb_full;
    assign w_ld      = w_from_hb || (!stall && w_rsp);
    assign w_ld_word = w_from_hb ? w_hb_word : rom_data;
    assign w_ld_addr = w_from_hb ? w_hb_addr : r_pend_addr;
    assign w_ld_hlt  = w_ld && (instr_opcode(w_ld_word) == OP_HLT);

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state and fetch strobe
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_rd_en = !stall && !rst;
                if (w_ld_hlt) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // PC and the tracker for the single in-flight request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
        end else begin
            r_pend <= w_rd_en;
            if (w_rd_en) begin
                r_pc        <= r_pc + C_PC_ONE;
                r_pend_addr <= r_pc;
            end
        end
    end

    // IF_ID register. With no word to load, a bubble is inserted and out_pc
    // keeps its old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode <= OP_NOP;
            r_ad1    <= '0;
            r_imm    <= '0;
            r_out_pc <= '0;
            r_valid  <= 1'b0;
        end else if (!stall) begin
            if (w_ld) begin
                r_opcode <= w_ld_word[OPC_MSB:OPC_LSB];
                r_ad1    <= w_ld_word[AD1_MSB:AD1_LSB];
                r_imm    <= w_ld_word[IMM_MSB:IMM_LSB];
                r_out_pc <= w_ld_addr;
                r_valid  <= 1'b1;
            end else begin
                r_opcode <= OP_NOP;
                r_ad1    <= '0;
                r_imm    <= '0;
                r_valid  <= 1'b0;
            end
        end
    end

    if_hold_buf #(
        .PC_W    (PC_W)
    ) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_rsp && stall),
        .i_drain (w_from_hb),
        .i_clear (w_ld_hlt),
        .i_word  (rom_data),
        .i_addr  (r_pend_addr),
        .o_full  (w_hb_full),
        .o_word  (w_hb_word),
        .o_addr  (w_hb_addr)
    );

    assign rom_rd_en  = w_rd_en;
    assign rom_addr   = r_pc;
    assign out_opcode = r_opcode;
    assign out_ad1    = r_ad1;
    assign out_imm    = r_imm;
    assign out_pc     = r_out_pc;
    assign out_valid  = r_valid;
    assign halted     = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Testbench with a scoreboard for if_stage. Two DUTs, with
//               RESET_PC 00 and FE, share one ROM model and one stall input.
//               The expected instruction stream is the ROM contents read in
//               address order from RESET_PC up to and including the first
//               HLT. A negedge monitor takes entries from the stream as
//               IF_ID loads them and checks bubbles, holds, halted, the
//               fetch strobe and the PC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] w;
    } item_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        rom_rd_en  [2];
    logic [7:0]  rom_addr   [2];
    logic [15:0] rom_data   [2];
    logic [2:0]  out_opcode [2];
    logic [4:0]  out_ad1    [2];
    logic [7:0]  out_imm    [2];
    logic [7:0]  out_pc     [2];
    logic        out_valid  [2];
    logic        halted     [2];

    logic [15:0] rom [256];
    item_t       exp_q [2][$];
    logic [7:0]  fetch_m   [2];
    logic        halted_m  [2];
    logic [7:0]  last_pc   [2];
    logic [24:0] snap      [2];
    int          first_vld [2];
    logic        prev_stall;
    logic        mon_on;
    int          cyc;
    int          n_chk;
    int          n_pass;

    if_stage #(.PC_W(8), .RESET_PC(8'h00)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .rom_rd_en  (rom_rd_en[0]),
        .rom_addr   (rom_addr[0]),
        .rom_data   (rom_data[0]),
        .out_opcode (out_opcode[0]),
        .out_ad1    (out_ad1[0]),
        .out_imm    (out_imm[0]),
        .out_pc     (out_pc[0]),
        .out_valid  (out_valid[0]),
        .halted     (halted[0])
    );

    if_stage #(.PC_W(8), .RESET_PC(8'hFE)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .rom_rd_en  (rom_rd_en[1]),
        .rom_addr   (rom_addr[1]),
        .rom_data   (rom_data[1]),
        .out_opcode (out_opcode[1]),
        .out_ad1    (out_ad1[1]),
        .out_imm    (out_imm[1]),
        .out_pc     (out_pc[1]),
        .out_valid  (out_valid[1]),
        .halted     (halted[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM with one cycle of latency. On cycles without a read it returns an
    // HLT-shaped junk word, so a spurious capture would be visible.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rom_data[k] <= rom_rd_en[k] ? rom[rom_addr[k]] : 16'hFFFF;
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            for (int k = 0; k < 2; k++) begin
                item_t       it;
                logic        e;
                logic [24:0] cur;
                cur = {out_valid[k], out_opcode[k], out_ad1[k], out_imm[k], out_pc[k]};
                if (!prev_stall) begin
                    if (out_valid[k]) begin
                        if (exp_q[k].size() == 0) begin
                            chk("extra_valid", k, 32'(out_valid[k]), 32'd0);
                        end else begin
                            it = exp_q[k].pop_front();
                            chk("out_pc", k, 32'(out_pc[k]), 32'(it.pc));
                            chk("opcode", k, 32'(out_opcode[k]), 32'(it.w[15:13]));
                            chk("ad1",    k, 32'(out_ad1[k]),    32'(it.w[12:8]));
                            chk("imm",    k, 32'(out_imm[k]),    32'(it.w[7:0]));
                            if (first_vld[k] < 0) first_vld[k] = cyc;
                            last_pc[k] = it.pc;
                            if (it.w[15:13] == 3'b111) halted_m[k] = 1'b1;
                        end
                    end else begin
                        chk("bubble_fields", k, 32'({out_opcode[k], out_ad1[k], out_imm[k]}), 32'd0);
                        chk("bubble_pc", k, 32'(out_pc[k]), 32'(last_pc[k]));
                    end
                end else begin
                    chk("stall_hold", k, 32'(cur), 32'(snap[k]));
                end
                chk("halted", k, 32'(halted[k]), 32'(halted_m[k]));
                e = !halted_m[k] && !stall;
                chk("rom_rd_en", k, 32'(rom_rd_en[k]), 32'(e));
                chk("rom_addr", k, 32'(rom_addr[k]), 32'(fetch_m[k]));
                if (e) fetch_m[k] = fetch_m[k] + 8'd1;
                snap[k] = cur;
            end
            prev_stall = stall;
            cyc++;
        end
    end

    task automatic fill_rom(input int hpos);
        for (int a = 0; a < 256; a++) begin
            rom[a] = {3'($urandom_range(6, 1)), 13'($urandom)};
        end
        if (hpos >= 0) rom[hpos] = {3'b111, 13'($urandom)};
    endtask

    // Reset, build the expected streams from the ROM, then release
    task automatic start_run();
        mon_on = 1'b0;
        rst    = 1'b1;
        stall  = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            logic [7:0] a;
            a = (k == 0) ? 8'h00 : 8'hFE;
            exp_q[k].delete();
            fetch_m[k]   = a;
            halted_m[k]  = 1'b0;
            last_pc[k]   = 8'h00;
            snap[k]      = 25'd0;
            first_vld[k] = -1;
            for (int i = 0; i < 256; i++) begin
                exp_q[k].push_back('{pc: a, w: rom[a]});
                if (rom[a][15:13] == 3'b111) break;
                a = a + 8'd1;
            end
        end
        prev_stall = 1'b1;
        cyc        = 0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic drive(input logic [127:0] svec, input int pct, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            stall = (c < ncyc - 20) && (svec[c] || (int'($urandom_range(99)) < pct));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_run();
        @(negedge clk);
        #1;
        mon_on = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("stream_drained", k, 32'(exp_q[k].size()), 32'd0);
            chk("halted_at_end", k, 32'(halted[k]), 32'd1);
        end
    endtask

    initial begin
        rst    = 1'b1;
        stall  = 1'b0;
        mon_on = 1'b0;
        n_chk  = 0;
        n_pass = 0;

        // LDO/LDA/ADD/HLT program with no stall. dut1 wraps FE, FF, 00, 01.
        fill_rom(-1);
        rom[0]   = 16'h2100;
        rom[1]   = 16'h4203;
        rom[2]   = 16'hA305;
        rom[3]   = 16'hE000;
        rom[254] = 16'h2100;
        rom[255] = 16'h2101;
        start_run();
        drive(128'd0, 0, 40);
        end_run();
        for (int k = 0; k < 2; k++) chk("first_latency", k, 32'(first_vld[k]), 32'd2);

        // Stall for 3 cycles right after the request for PC 1
        fill_rom(10);
        start_run();
        drive(128'h1C, 0, 60);
        end_run();

        // HLT at 4: the request for 5 is dropped and the PC stops at 6
        fill_rom(4);
        rom[5] = 16'h2100;
        start_run();
        drive(128'd0, 0, 40);
        end_run();
        chk("pc_stop", 0, 32'(rom_addr[0]), 32'h06);

        // HLT arrives under stall and sits in the hold buffer for a while
        fill_rom(3);
        start_run();
        drive(128'hF0, 0, 40);
        end_run();

        // Reset asserted while requests are in flight
        fill_rom(12);
        start_run();
        @(posedge clk);
        @(posedge clk);
        #2;
        mon_on = 1'b0;
        rst    = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid",  k, 32'(out_valid[k]), 32'd0);
            chk("rst_fields", k, 32'({out_opcode[k], out_ad1[k], out_imm[k]}), 32'd0);
            chk("rst_pc",     k, 32'(out_pc[k]), 32'd0);
            chk("rst_halted", k, 32'(halted[k]), 32'd0);
            chk("rst_rd_en",  k, 32'(rom_rd_en[k]), 32'd0);
        end
        start_run();
        drive(128'd0, 0, 50);
        end_run();

        // Random programs under random stall
        for (int r = 0; r < 8; r++) begin
            fill_rom(int'($urandom_range(25, 3)));
            start_run();
            drive(128'd0, 30, 120);
            end_run();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
